fgc_ctrl: RTL and testbench

- Move sequencer for the fox/goat/cabbage river-crossing core.
- Accepts single move requests from a player port, or runs the fixed 7-move solution on `start_i`.
- Checks each move for legality and safety before issuing it to the core.
- Issues the move as a one-cycle strobe, waits for the core's bank feedback, and reports one response code per transaction.

---
 rtl/fgc_pkg.sv | 45 ++++
 rtl/fgc_move_check.sv | 33 +++
 rtl/fgc_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fgc_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fgc_pkg.sv
// Shared types and constants for the fox/goat/cabbage move sequencer.
package fgc_pkg;

    typedef enum logic [1:0] {
        ITEM_NONE    = 2'd0,
        ITEM_FOX     = 2'd1,
        ITEM_GOAT    = 2'd2,
        ITEM_CABBAGE = 2'd3
    } item_t;

    typedef enum logic [1:0] {
        RSP_OK       = 2'd0,
        RSP_ILLEGAL  = 2'd1,
        RSP_TIMEOUT  = 2'd2,
        RSP_MISMATCH = 2'd3
    } rsp_code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic m;
        logic f;
        logic g;
        logic c;
    } banks_t;

    localparam int unsigned N_STEPS = 7;

    localparam item_t SOLUTION [0:6] = '{
        ITEM_GOAT, ITEM_NONE, ITEM_FOX, ITEM_GOAT,
        ITEM_CABBAGE, ITEM_NONE, ITEM_GOAT
    };

    function automatic logic is_safe(banks_t b);
        return !((b.f == b.g && b.m != b.f) ||
                 (b.g == b.c && b.m != b.g));
    endfunction

endpackage

// File: rtl/fgc_move_check.sv
// Combinational move legality check and next-state bank computation.
module fgc_move_check
    import fgc_pkg::*;
(
    input  banks_t banks_i,
    input  item_t  item_i,
    output logic   legal_o,
    output banks_t next_o
);

    always_comb begin
        next_o   = banks_i;
        next_o.m = ~banks_i.m;
        legal_o  = 1'b1;
        unique case (item_i)
            ITEM_NONE: legal_o = 1'b1;
            ITEM_FOX: begin
                legal_o  = (banks_i.f == banks_i.m);
                next_o.f = ~banks_i.f;
            end
            ITEM_GOAT: begin
                legal_o  = (banks_i.g == banks_i.m);
                next_o.g = ~banks_i.g;
            end
            ITEM_CABBAGE: begin
                legal_o  = (banks_i.c == banks_i.m);
                next_o.c = ~banks_i.c;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fgc_ctrl.sv
// Move sequencer: manual requests or 7-step auto-solve, one response each.
// Define FGC_CTRL_FORMAL_EN to compile the embedded assertions and covers.
module fgc_ctrl
    import fgc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             req_valid_i,
    input  logic [1:0]       req_item_i,
    output logic             req_ready_o,
    output logic             rsp_valid_o,
    output logic [1:0]       rsp_code_o,
    output logic [1:0]       item_o,
    output logic             move_o,
    input  logic             bank_f_i,
    input  logic             bank_g_i,
    input  logic             bank_c_i,
    input  logic             bank_m_i,
    output logic             busy_o,
    output logic             solved_o,
    output logic [CNT_W-1:0] moves_o
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic             auto_q, auto_d;
    logic [2:0]       step_q, step_d;
    item_t            item_q, item_d;
    banks_t           exp_q, exp_d;
    logic             mpre_q, mpre_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    rsp_code_t        code_q, code_d;
    logic [CNT_W-1:0] moves_q, moves_d;
    logic             solved_q;

    banks_t banks;
    item_t  cur_item;
    logic   chk_legal;
    banks_t chk_next;

    assign banks    = {bank_m_i, bank_f_i, bank_g_i, bank_c_i};
    assign cur_item = auto_q ? SOLUTION[step_q] : item_q;

    fgc_move_check u_check (
        .banks_i (banks),
        .item_i  (cur_item),
        .legal_o (chk_legal),
        .next_o  (chk_next)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            auto_q   <= 1'b0;
            step_q   <= '0;
            item_q   <= ITEM_NONE;
            exp_q    <= '0;
            mpre_q   <= 1'b0;
            tmr_q    <= '0;
            code_q   <= RSP_OK;
            moves_q  <= '0;
            solved_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            auto_q   <= auto_d;
            step_q   <= step_d;
            item_q   <= item_d;
            exp_q    <= exp_d;
            mpre_q   <= mpre_d;
            tmr_q    <= tmr_d;
            code_q   <= code_d;
            moves_q  <= moves_d;
            solved_q <= &banks;
        end
    end

    always_comb begin
        state_d = state_q;
        auto_d  = auto_q;
        step_d  = step_q;
        item_d  = item_q;
        exp_d   = exp_q;
        mpre_d  = mpre_q;
        tmr_d   = tmr_q;
        code_d  = code_q;
        moves_d = moves_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    auto_d = 1'b1;
                    step_d = '0;
                    if (banks != '0) begin
                        code_d  = RSP_ILLEGAL;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_CHECK;
                    end
                end else if (req_valid_i) begin
                    auto_d  = 1'b0;
                    item_d  = item_t'(req_item_i);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!chk_legal || !is_safe(chk_next)) begin
                    code_d  = RSP_ILLEGAL;
                    state_d = S_RESP;
                end else begin
                    exp_d   = chk_next;
                    mpre_d  = bank_m_i;
                    item_d  = cur_item;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A man-bank toggle takes precedence over an expiring timer.
                if (bank_m_i != mpre_q) begin
                    if (banks == exp_q) begin
                        if (moves_q != '1) moves_d = moves_q + 1'b1;
                        if (auto_q && step_q != 3'(N_STEPS - 1)) begin
                            step_d  = step_q + 3'd1;
                            state_d = S_CHECK;
                        end else begin
                            code_d  = RSP_OK;
                            state_d = S_RESP;
                        end
                    end else begin
                        code_d  = RSP_MISMATCH;
                        state_d = S_RESP;
                    end
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    code_d  = RSP_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = rst_ni && (state_q == S_IDLE) && !start_i;
        move_o      = (state_q == S_ISSUE);
        item_o      = (state_q == S_ISSUE) ? item_q : ITEM_NONE;
        rsp_valid_o = (state_q == S_RESP);
        rsp_code_o  = code_q;
        busy_o      = (state_q != S_IDLE);
        solved_o    = solved_q;
        moves_o     = moves_q;
    end

`ifdef FGC_CTRL_FORMAL_EN
    logic   f_legal;
    banks_t f_next;

    fgc_move_check u_fcheck (
        .banks_i (banks),
        .item_i  (item_t'(item_o)),
        .legal_o (f_legal),
        .next_o  (f_next)
    );

    a_move_in_issue: assert property (@(posedge clk_i) disable iff (!rst_ni)
        move_o |-> state_q == S_ISSUE);
    a_move_safe: assert property (@(posedge clk_i) disable iff (!rst_ni)
        move_o |-> f_legal && is_safe(f_next));
    a_rsp_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_o |=> !rsp_valid_o);
    a_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        busy_o == (state_q != S_IDLE));
    c_auto_ok: cover property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_o && auto_q && rsp_code_o == RSP_OK && solved_o);
`endif

endmodule

// File: tb/tb_fgc_ctrl.sv
// Randomized self-checking bench for fgc_ctrl with a behavioural core model.
module tb_fgc_ctrl;

    localparam int TMO  = 15;
    localparam int C_OK = 0;
    localparam int C_IL = 1;
    localparam int C_TO = 2;
    localparam int C_MM = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_item = 2'd0;
    logic [3:0] pos = 4'd0;
    logic       req_ready, rsp_valid, move, busy, solved;
    logic [1:0] rsp_code, item;
    logic [7:0] moves;

    always #5 clk = ~clk;

    fgc_ctrl #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .req_valid_i (req_valid),
        .req_item_i  (req_item),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_code_o  (rsp_code),
        .item_o      (item),
        .move_o      (move),
        .bank_f_i    (pos[1]),
        .bank_g_i    (pos[2]),
        .bank_c_i    (pos[3]),
        .bank_m_i    (pos[0]),
        .busy_o      (busy),
        .solved_o    (solved),
        .moves_o     (moves)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int mv_cyc = 0;
    int rsp_cyc = 0;
    int exp_moves = 0;
    int mv_q[$];
    int rsp_q[$];
    int core_mode = 0;
    bit core_kill = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (move) begin
            mv_q.push_back(int'(item));
            mv_cyc = cyc;
        end
        if (rsp_valid) begin
            rsp_q.push_back(int'(rsp_code));
            rsp_cyc = cyc;
        end
    end

    // pos[0]=man, pos[k]=bank of item k; core answers 2 cycles after a move
    initial begin : core
        int it;
        forever begin
            @(negedge clk);
            if (move && core_mode != 1) begin
                it = int'(item);
                core_kill = 0;
                repeat (2) @(negedge clk);
                if (!core_kill) begin
                    if (core_mode == 2) begin
                        pos = 4'b0011;
                    end else begin
                        pos[0] = ~pos[0];
                        if (it != 0) pos[it] = ~pos[it];
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic int predict(logic [3:0] p, int it, bit silent);
        logic [3:0] n;
        bit legal, safe;
        legal = (it == 0) || (p[it] == p[0]);
        n = p;
        n[0] = ~n[0];
        if (it != 0) n[it] = ~n[it];
        safe = !((n[1] == n[2] && n[0] != n[1]) ||
                 (n[2] == n[3] && n[0] != n[2]));
        if (!legal || !safe) return C_IL;
        return silent ? C_TO : C_OK;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        mv_q.delete();
        rsp_q.delete();
    endtask

    task automatic wait_rsp(input int bound, input string name,
                            output int code);
        code = -1;
        for (int i = 0; i < bound && rsp_q.size() == 0; i++) step();
        if (rsp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no response within %0d cycles", name, bound);
        end else begin
            code = rsp_q.pop_front();
        end
    endtask

    task automatic do_req(input int it, output int k);
        step();
        req_valid = 1'b1;
        req_item  = 2'(it);
        k = cyc;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_tests++;
        if ({rsp_valid, move, busy, solved, req_ready, item, rsp_code} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 0",
                     {rsp_valid, move, busy, solved, req_ready, item, rsp_code});
        end
        n_tests++;
        if (moves !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_moves: got %0d want 0", moves);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic run_auto(input string name);
        int code;
        int exp_items[7] = '{2, 0, 1, 2, 3, 0, 2};
        clear_q();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_rsp(200, name, code);
        n_tests++;
        if (code !== C_OK) begin
            n_fail++;
            $display("FAIL %s_code: got %0d want %0d", name, code, C_OK);
        end
        n_tests++;
        if (mv_q.size() != 7) begin
            n_fail++;
            $display("FAIL %s_nmoves: got %0d want 7", name, mv_q.size());
        end
        for (int i = 0; i < 7 && i < mv_q.size(); i++) begin
            n_tests++;
            if (mv_q[i] != exp_items[i]) begin
                n_fail++;
                $display("FAIL %s_item%0d: got %0d want %0d",
                         name, i, mv_q[i], exp_items[i]);
            end
        end
        exp_moves = exp_moves + 7;
        n_tests++;
        if (solved !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_solved: got %b want 1", name, solved);
        end
        n_tests++;
        if (moves !== 8'(exp_moves)) begin
            n_fail++;
            $display("FAIL %s_moves: got %0d want %0d", name, moves, exp_moves);
        end
        repeat (6) step();
        n_tests++;
        if (rsp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_extra_rsp: got %0d want 0", name, rsp_q.size());
        end
    endtask

    task automatic test_auto();
        pos = 4'd0;
        run_auto("auto");
    endtask

    task automatic test_manual_illegal(input string name, input logic [3:0] p,
                                       input int it);
        int k, code;
        pos = p;
        clear_q();
        do_req(it, k);
        wait_rsp(20, name, code);
        n_tests++;
        if (code !== C_IL) begin
            n_fail++;
            $display("FAIL %s_code: got %0d want %0d", name, code, C_IL);
        end
        n_tests++;
        if (code == C_IL && rsp_cyc - k != 2) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want 2", name, rsp_cyc - k);
        end
        n_tests++;
        if (mv_q.size() != 0 || moves !== 8'(exp_moves)) begin
            n_fail++;
            $display("FAIL %s_nomove: got moves=%0d strobes=%0d want %0d/0",
                     name, moves, mv_q.size(), exp_moves);
        end
    endtask

    task automatic test_timeout();
        int k, code;
        pos = 4'd0;
        core_mode = 1;
        clear_q();
        do_req(2, k);
        wait_rsp(60, "timeout", code);
        n_tests++;
        if (code !== C_TO) begin
            n_fail++;
            $display("FAIL timeout_code: got %0d want %0d", code, C_TO);
        end
        n_tests++;
        if (rsp_cyc - mv_cyc != TMO + 1 || mv_q.size() != 1) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d want %0d",
                     rsp_cyc - mv_cyc, TMO + 1);
        end
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_busy: got %b want 0", busy);
        end
        core_mode = 0;
    endtask

    task automatic test_mismatch();
        int k, code;
        pos = 4'd0;
        core_mode = 2;
        clear_q();
        do_req(2, k);
        wait_rsp(40, "mismatch", code);
        n_tests++;
        if (code !== C_MM) begin
            n_fail++;
            $display("FAIL mismatch_code: got %0d want %0d", code, C_MM);
        end
        n_tests++;
        if (moves !== 8'(exp_moves)) begin
            n_fail++;
            $display("FAIL mismatch_moves: got %0d want %0d", moves, exp_moves);
        end
        core_mode = 0;
        pos = 4'd0;
    endtask

    task automatic test_random();
        int k, code, it, want, nmv;
        bit silent;
        for (int n = 0; n < 40; n++) begin
            pos    = 4'($urandom_range(0, 15));
            it     = int'($urandom_range(0, 3));
            silent = ($urandom_range(0, 5) == 0);
            core_mode = silent ? 1 : 0;
            want = predict(pos, it, silent);
            repeat ($urandom_range(0, 2)) step();
            clear_q();
            step();
            n_tests++;
            if (solved !== (&pos)) begin
                n_fail++;
                $display("FAIL rnd%0d_solved: got %b want %b", n, solved, &pos);
            end
            do_req(it, k);
            wait_rsp(60, "rnd", code);
            if (want == C_OK) exp_moves++;
            nmv = (want == C_IL) ? 0 : 1;
            n_tests++;
            if (code !== want || mv_q.size() != nmv) begin
                n_fail++;
                $display("FAIL rnd%0d_code: banks=%b item=%0d got %0d/%0d want %0d/%0d",
                         n, pos, it, code, mv_q.size(), want, nmv);
            end
            n_tests++;
            if (moves !== 8'(exp_moves)) begin
                n_fail++;
                $display("FAIL rnd%0d_moves: got %0d want %0d", n, moves, exp_moves);
            end
        end
        core_mode = 0;
    endtask

    task automatic test_priority_reset();
        int i;
        pos = 4'd0;
        clear_q();
        step();
        start     = 1'b1;
        req_valid = 1'b1;
        req_item  = 2'd2;
        #1;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_ready: got %b want 0", req_ready);
        end
        step();
        start     = 1'b0;
        req_valid = 1'b0;
        for (i = 0; i < 100 && mv_q.size() < 4; i++) step();
        n_tests++;
        if (mv_q.size() < 4) begin
            n_fail++;
            $display("FAIL prio_step3: got %0d strobes want 4", mv_q.size());
        end
        step();
        core_kill = 1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid, move, busy, solved, req_ready, item, rsp_code, moves} !== '0) begin
            n_fail++;
            $display("FAIL prio_reset_outs: got %b want 0",
                     {rsp_valid, move, busy, solved, req_ready, item, rsp_code, moves});
        end
        rsp_q.delete();
        repeat (3) step();
        pos = 4'd0;
        rst_n = 1'b1;
        exp_moves = 0;
        repeat (3) step();
        n_tests++;
        if (rsp_q.size() != 0 || busy !== 1'b0 || moves !== 8'd0) begin
            n_fail++;
            $display("FAIL prio_after_reset: got rsp=%0d busy=%b moves=%0d want 0/0/0",
                     rsp_q.size(), busy, moves);
        end
        run_auto("restart");
    endtask

    initial begin
        test_reset();
        test_auto();
        test_manual_illegal("fox_first", 4'b0000, 1);
        test_manual_illegal("far_cabbage", 4'b0011, 3);
        test_timeout();
        test_mismatch();
        test_random();
        test_priority_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
